// File: rtl/tcm_block_mover_pkg.sv
// Shared types for the TCM block mover.
// State encoding, opcode values and address-width helper.
package tcm_block_mover_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RWAIT,
      S_WR,
      S_WWAIT,
      S_FIN
   } state_t;

   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

   function automatic int aw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tcm_block_mover.sv
// Block copy / fill engine driving the second port of the TCM SRAM.
// One access in flight at a time; every output is registered.
module tcm_block_mover
   import tcm_block_mover_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_ENTRIES  = 1024,
   parameter int TIMEOUT    = 15,
   localparam int AW        = aw_of(N_ENTRIES),
   localparam int BW        = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  op_i,
   input  logic [AW-1:0]         src_i,
   input  logic [AW-1:0]         dst_i,
   input  logic [AW:0]           len_i,
   input  logic [DATA_WIDTH-1:0] fill_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [AW:0]           count_o,
   output logic                  en_o,
   output logic                  we_o,
   output logic [BW-1:0]         be_o,
   output logic [AW-1:0]         addr_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  ready_i
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t                state, state_nx;
   logic                  op, op_nx;
   logic [AW-1:0]         src, src_nx;
   logic [AW-1:0]         dst, dst_nx;
   logic [AW:0]           len, len_nx;
   logic [DATA_WIDTH-1:0] fill, fill_nx;
   logic [TW-1:0]         wait_cnt, wait_nx;

   logic                  busy_nx, done_nx, err_nx;
   logic                  en_nx, we_nx;
   logic [BW-1:0]         be_nx;
   logic [AW-1:0]         addr_nx;
   logic [DATA_WIDTH-1:0] data_nx;
   logic [AW:0]           count_nx, count_inc;
   logic [AW-1:0]         src_inc, dst_inc;
   logic                  timed_out;

   // Pointers wrap modulo N_ENTRIES, which need not be a power of two
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(N_ENTRIES - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      state_nx  = state;
      op_nx     = op;
      src_nx    = src;
      dst_nx    = dst;
      len_nx    = len;
      fill_nx   = fill;
      wait_nx   = wait_cnt;
      err_nx    = err_o;
      count_nx  = count_o;
      en_nx     = 1'b0;
      we_nx     = 1'b0;
      be_nx     = '0;
      addr_nx   = addr_o;
      data_nx   = data_o;
      count_inc = count_o + (AW+1)'(1);
      src_inc   = wrap_inc(src);
      dst_inc   = wrap_inc(dst);
      timed_out = (wait_cnt == TW'(TIMEOUT - 1));

      unique case (state)
         S_IDLE: begin
            if (start_i) begin
               op_nx    = op_i;
               src_nx   = src_i;
               dst_nx   = dst_i;
               len_nx   = len_i;
               fill_nx  = fill_data_i;
               count_nx = '0;
               err_nx   = 1'b0;
               if (len_i == '0) begin
                  state_nx = S_FIN;
               end else if (op_i == OP_FILL) begin
                  state_nx = S_WR;
                  en_nx    = 1'b1;
                  we_nx    = 1'b1;
                  be_nx    = '1;
                  addr_nx  = dst_i;
                  data_nx  = fill_data_i;
               end else begin
                  state_nx = S_RD;
                  en_nx    = 1'b1;
                  addr_nx  = src_i;
               end
            end
         end
         S_RD: begin
            state_nx = S_RWAIT;
            wait_nx  = '0;
         end
         S_RWAIT: begin
            if (ready_i) begin
               state_nx = S_WR;
               en_nx    = 1'b1;
               we_nx    = 1'b1;
               be_nx    = '1;
               addr_nx  = dst;
               data_nx  = data_i;
            end else if (timed_out) begin
               state_nx = S_FIN;
               err_nx   = 1'b1;
            end else begin
               wait_nx = wait_cnt + TW'(1);
            end
         end
         S_WR: begin
            state_nx = S_WWAIT;
            wait_nx  = '0;
         end
         S_WWAIT: begin
            if (ready_i) begin
               count_nx = count_inc;
               src_nx   = src_inc;
               dst_nx   = dst_inc;
               if (count_inc == len) begin
                  state_nx = S_FIN;
               end else if (op == OP_FILL) begin
                  state_nx = S_WR;
                  en_nx    = 1'b1;
                  we_nx    = 1'b1;
                  be_nx    = '1;
                  addr_nx  = dst_inc;
                  data_nx  = fill;
               end else begin
                  state_nx = S_RD;
                  en_nx    = 1'b1;
                  addr_nx  = src_inc;
               end
            end else if (timed_out) begin
               state_nx = S_FIN;
               err_nx   = 1'b1;
            end else begin
               wait_nx = wait_cnt + TW'(1);
            end
         end
         S_FIN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      done_nx = (state_nx == S_FIN);
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         op       <= OP_COPY;
         src      <= '0;
         dst      <= '0;
         len      <= '0;
         fill     <= '0;
         wait_cnt <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         count_o  <= '0;
         en_o     <= 1'b0;
         we_o     <= 1'b0;
         be_o     <= '0;
         addr_o   <= '0;
         data_o   <= '0;
      end else begin
         state    <= state_nx;
         op       <= op_nx;
         src      <= src_nx;
         dst      <= dst_nx;
         len      <= len_nx;
         fill     <= fill_nx;
         wait_cnt <= wait_nx;
         busy_o   <= busy_nx;
         done_o   <= done_nx;
         err_o    <= err_nx;
         count_o  <= count_nx;
         en_o     <= en_nx;
         we_o     <= we_nx;
         be_o     <= be_nx;
         addr_o   <= addr_nx;
         data_o   <= data_nx;
      end
   end

endmodule

// File: tb/tb_tcm_block_mover.sv
// Bench for tcm_block_mover: behavioural SRAM port plus a word-array
// reference of the block operations, random and directed commands.
module tb_tcm_block_mover;

   localparam int DW = 32;
   localparam int N  = 1024;
   localparam int AW = 10;
   localparam int TO = 15;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          op_i = 1'b0;
   logic [AW-1:0] src_i = '0;
   logic [AW-1:0] dst_i = '0;
   logic [AW:0]   len_i = '0;
   logic [DW-1:0] fill_data_i = '0;
   logic [DW-1:0] data_i = '0;
   logic          ready_i = 1'b0;
   logic          busy_o, done_o, err_o, en_o, we_o;
   logic [AW:0]   count_o;
   logic [3:0]    be_o;
   logic [AW-1:0] addr_o;
   logic [DW-1:0] data_o;

   tcm_block_mover #(
      .DATA_WIDTH(DW),
      .N_ENTRIES (N),
      .TIMEOUT   (TO)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .op_i       (op_i),
      .src_i      (src_i),
      .dst_i      (dst_i),
      .len_i      (len_i),
      .fill_data_i(fill_data_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .count_o    (count_o),
      .en_o       (en_o),
      .we_o       (we_o),
      .be_o       (be_o),
      .addr_o     (addr_o),
      .data_o     (data_o),
      .data_i     (data_i),
      .ready_i    (ready_i)
   );

   always #5 clk_i = ~clk_i;

   logic [DW-1:0] mem  [N];
   logic [DW-1:0] refm [N];
   int            checks = 0;
   int            errors = 0;
   int            en_cnt = 0;
   int            wr_cnt = 0;
   int            done_cnt = 0;
   int            bad_ctl = 0;
   int            wl = -1;
   int            max_dly = 0;
   int            stall_at = -1;
   int            dly;
   logic          stalled;
   logic [DW-1:0] wtmp;
   logic [AW-1:0] rd_q[$];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // SRAM port: ready one cycle after the access plus optional extra delay
   always @(posedge clk_i) begin
      ready_i <= 1'b0;
      if (done_o) done_cnt++;
      if (en_o && we_o && be_o != 4'hF) bad_ctl++;
      if (!en_o && (we_o || be_o != 4'h0)) bad_ctl++;
      if (en_o) begin
         en_cnt++;
         stalled = 1'b0;
         if (we_o) begin
            wtmp = mem[addr_o];
            for (int b = 0; b < DW/8; b++)
               if (be_o[b]) wtmp[8*b +: 8] = data_o[8*b +: 8];
            mem[addr_o] = wtmp;
            wr_cnt++;
            stalled = (stall_at >= 0) && (wr_cnt > stall_at);
         end else begin
            data_i <= mem[addr_o];
            rd_q.push_back(addr_o);
         end
         wl = -1;
         if (!stalled) begin
            dly = (max_dly > 0) ? $urandom_range(max_dly, 0) : 0;
            if (dly == 0) ready_i <= 1'b1;
            else wl = dly;
         end
      end else if (wl > 0) begin
         wl--;
         if (wl == 0) begin
            ready_i <= 1'b1;
            wl = -1;
         end
      end
   end

   task automatic apply_ref(input logic op, input int src, input int dst,
                            input int len, input logic [DW-1:0] fill);
      for (int i = 0; i < len; i++)
         refm[(dst + i) % N] = op ? fill : refm[(src + i) % N];
   endtask

   function automatic int mem_diffs();
      int d = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] !== refm[i]) d++;
      return d;
   endfunction

   function automatic logic [63:0] outs();
      return {2'b0, busy_o, done_o, err_o, en_o, we_o, be_o,
              count_o, addr_o, data_o};
   endfunction

   // exp_lat < 0 skips the latency check (random ready delays)
   task automatic run_cmd(input string tag, input logic op, input int src,
                          input int dst, input int len,
                          input logic [DW-1:0] fill, input int exp_lat,
                          input int exp_cnt, input logic exp_err);
      int n;
      int done0;
      @(negedge clk_i);
      op_i        = op;
      src_i       = AW'(src);
      dst_i       = AW'(dst);
      len_i       = (AW+1)'(len);
      fill_data_i = fill;
      start_i     = 1'b1;
      en_cnt      = 0;
      wr_cnt      = 0;
      done0       = done_cnt;
      rd_q.delete();
      @(negedge clk_i);
      start_i = 1'b0;
      n = 1;
      while (!done_o && n < 4000) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_done"}, done_o, 1);
      if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
      check({tag, "_count"}, count_o, exp_cnt);
      check({tag, "_err"}, err_o, exp_err);
      if (!exp_err) check({tag, "_en"}, en_cnt, op ? len : 2 * len);
      @(negedge clk_i);
      check({tag, "_pulse"}, {done_o, busy_o}, 0);
      check({tag, "_ndone"}, done_cnt - done0, 1);
   endtask

   initial begin
      int op, src, dst, len, n, done0;
      logic [DW-1:0] fill, orig;

      for (int i = 0; i < N; i++) begin
         mem[i]  = $urandom;
         refm[i] = mem[i];
      end
      repeat (3) @(negedge clk_i);
      check("reset_outs", outs(), 0);
      rst_i = 1'b0;

      run_cmd("fill", 1'b1, 77, 10, 4, 32'hDEADBEEF, 9, 4, 1'b0);
      apply_ref(1'b1, 77, 10, 4, 32'hDEADBEEF);
      check("fill_w13", mem[13], 32'hDEADBEEF);
      check("fill_mem", mem_diffs(), 0);

      for (int i = 0; i < 8; i++) begin
         mem[i]  = DW'(i);
         refm[i] = DW'(i);
      end
      run_cmd("copy", 1'b0, 0, 100, 8, '0, 33, 8, 1'b0);
      apply_ref(1'b0, 0, 100, 8, '0);
      check("copy_w107", mem[107], 7);
      check("copy_mem", mem_diffs(), 0);

      run_cmd("wrap", 1'b0, 1022, 1, 4, '0, 17, 4, 1'b0);
      apply_ref(1'b0, 1022, 1, 4, '0);
      check("wrap_nrd", rd_q.size(), 4);
      for (int i = 0; i < 4 && i < rd_q.size(); i++)
         check("wrap_rdaddr", rd_q[i], (1022 + i) % N);
      check("wrap_mem", mem_diffs(), 0);

      orig = mem[200];
      run_cmd("prop", 1'b0, 200, 201, 5, '0, 21, 5, 1'b0);
      apply_ref(1'b0, 200, 201, 5, '0);
      check("prop_w205", mem[205], orig);
      check("prop_mem", mem_diffs(), 0);

      run_cmd("len0", 1'b0, 5, 6, 0, '0, 1, 0, 1'b0);

      stall_at = 2;
      run_cmd("tmo", 1'b1, 300, 300, 6, 32'h5A5A0F0F, 2*2 + 2 + TO, 2, 1'b1);
      stall_at = -1;
      apply_ref(1'b1, 300, 300, 3, 32'h5A5A0F0F);
      repeat (2) @(negedge clk_i);
      run_cmd("clr", 1'b1, 400, 400, 1, 32'h11112222, 3, 1, 1'b0);
      apply_ref(1'b1, 400, 400, 1, 32'h11112222);

      run_cmd("full", 1'b1, 517, 517, N, 32'hCAFEF00D, 1 + 2*N, N, 1'b0);
      apply_ref(1'b1, 517, 517, N, 32'hCAFEF00D);
      check("full_mem", mem_diffs(), 0);
      for (int i = 0; i < N; i++) begin
         mem[i]  = $urandom;
         refm[i] = mem[i];
      end

      for (int k = 0; k < 14; k++) begin
         max_dly = (k % 2 == 1) ? 3 : 0;
         op   = $urandom_range(1, 0);
         src  = (k % 4 == 3) ? $urandom_range(N - 1, N - 20)
                             : $urandom_range(N - 1, 0);
         dst  = $urandom_range(N - 1, 0);
         len  = $urandom_range(48, 1);
         fill = $urandom;
         run_cmd("rand", op[0], src, dst, len, fill,
                 (max_dly == 0) ? 1 + len * (op[0] ? 2 : 4) : -1,
                 len, 1'b0);
         apply_ref(op[0], src, dst, len, fill);
         check("rand_mem", mem_diffs(), 0);
      end
      max_dly = 0;

      // start held high while busy, with different arguments
      @(negedge clk_i);
      op_i = 1'b0; src_i = AW'(50); dst_i = AW'(600);
      len_i = (AW+1)'(6); start_i = 1'b1;
      done0 = done_cnt;
      @(negedge clk_i);
      op_i = 1'b1; dst_i = AW'(700); len_i = (AW+1)'(9);
      fill_data_i = 32'h0BADF00D;
      n = 1;
      while (!done_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      start_i = 1'b0;
      check("busy_done", done_o, 1);
      check("busy_count", count_o, 6);
      apply_ref(1'b0, 50, 600, 6, '0);
      repeat (3) @(negedge clk_i);
      check("busy_idle", busy_o, 0);
      check("busy_ndone", done_cnt - done0, 1);
      check("busy_mem", mem_diffs(), 0);

      // reset in the middle of a copy
      @(negedge clk_i);
      op_i = 1'b0; src_i = AW'(10); dst_i = AW'(800);
      len_i = (AW+1)'(30); start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (8) @(negedge clk_i);
      check("mid_busy", busy_o, 1);
      done0 = done_cnt;
      rst_i = 1'b1;
      #1;
      check("mid_rst_outs", outs(), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (6) @(negedge clk_i);
      check("mid_ndone", done_cnt - done0, 0);
      check("mid_idle", outs(), 0);

      check("ctl_rules", bad_ctl, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
